data_sram_ctrl: RTL and testbench
=================================

DATA_SRAM_CTRL -- requirements
Module: data_sram_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising edge.
REQ-002 SHALL have port: resetn  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: mem_en  in  1  M-stage load/store valid; upstream already gates it with address exceptions.
REQ-004 SHALL have port: mem_wen  in  4  byte write strobes; 0000 means load.
REQ-005 SHALL have port: mem_load_size  in  2  load size: 0 = byte, 1 = half, 2 = word.
REQ-006 SHALL have ports: mem_addr  in  32  byte address; mem_wdata  in  32  store data, already lane-replicated.
REQ-007 SHALL have ports: flush  in  1  M-stage exception flush; longest_stall  in  1  pipeline held by another source.
REQ-008 SHALL have ports: data_req out 1; data_wr out 1; data_size out 2; data_addr out 32; data_wdata out 32.
REQ-009 SHALL have ports: data_addr_ok in 1; data_data_ok in 1; data_rdata in 32 (sram-like slave).
REQ-010 SHALL have ports: mem_rdata  out  32  captured load data; mem_stall  out  1  pipeline stall request.

Function
REQ-011 SHALL implement FSM states: IDLE, ADDR (request pending), DATA (awaiting data_ok), HOLD (done, result held).
REQ-012 SHALL assert data_req combinationally when (IDLE & mem_en & !flush) or when in ADDR.
REQ-013 SHALL transition IDLE->DATA on data_req & data_addr_ok, and IDLE->ADDR on data_req & !data_addr_ok.
REQ-014 SHALL transition ADDR->DATA on data_addr_ok, and hold data_req plus all request fields stable while in ADDR.
REQ-015 SHALL ignore data_data_ok outside DATA; on DATA & data_data_ok, SHALL register data_rdata into mem_rdata and go to HOLD.
REQ-016 SHALL transition HOLD->IDLE when longest_stall==0 or flush==1; otherwise remain in HOLD with mem_rdata unchanged.
REQ-017 SHALL drive mem_stall = (IDLE & mem_en & !flush) | ADDR | DATA; mem_stall SHALL be 0 in HOLD.
REQ-018 SHALL drive data_wr = |mem_wen.
REQ-019 SHALL drive data_size on stores from mem_wen: single-bit strobe gives 0, 0011/1100 gives 1, 1111 gives 2; any other strobe pattern SHALL suppress data_req.
REQ-020 SHALL drive data_size on loads from mem_load_size.
REQ-021 SHALL pass data_wdata = mem_wdata and set data_addr per REQ-026/027.
REQ-022 SHALL let flush cancel only an unissued request (IDLE); once in ADDR/DATA the transaction SHALL complete, then HOLD SHALL exit on the next cycle.
REQ-023 SHALL keep minimum latency request-to-result at 2 cycles (addr_ok in cycle 0, data_ok in cycle 1, result valid in HOLD at cycle 2).

Reset
REQ-024 SHALL on resetn==0 immediately force state IDLE, mem_rdata 0; data_req, mem_stall therefore 0 while resetn low.
REQ-025 SHALL abandon any in-flight transaction when reset asserts mid-operation; no late data_ok SHALL be captured after reset.

Configuration
REQ-026 With ADDR_MAP_EN defined, data_addr SHALL be {3'b000, mem_addr[28:0]} when mem_addr[31:30]==2'b10 (kseg0/kseg1), else mem_addr.
REQ-027 Without ADDR_MAP_EN, data_addr SHALL equal mem_addr unchanged.

Structure
REQ-028 SHALL take FSM state encodings and size constants (SIZE_BYTE/HALF/WORD) from the shared defines header.
REQ-029 SHALL place address translation in one combinational sub-module, addr_map, instantiated only under ADDR_MAP_EN.

Verification
REQ-030 Store with mem_wen=0100, addr 0x00000002, addr_ok in cycle 0, data_ok in cycle 2 -> data_wr=1, size=0, mem_stall high for cycles 0-2, low in cycle 3.
REQ-031 Load word at 0x80001000, size 2, with ADDR_MAP_EN -> data_addr=0x00001000; data_rdata 0xDEADBEEF -> mem_rdata=0xDEADBEEF in HOLD.
REQ-032 Load with addr_ok delayed 3 cycles -> data_req and data_addr held constant throughout ADDR; mem_stall stays 1.
REQ-033 data_ok arrives while longest_stall=1 for 4 cycles -> FSM stays in HOLD, mem_rdata stable, mem_stall=0, no new data_req.
REQ-034 flush=1 with mem_en=1 in IDLE -> data_req=0, mem_stall=0; flush during DATA -> data_ok is still consumed, then IDLE.
REQ-035 resetn pulled low in DATA, then released; later data_ok -> ignored, mem_rdata=0, state IDLE.

Source files
------------

// File: rtl/data_sram_ctrl_pkg.sv
// Shared definitions for the M-stage data SRAM controller:
// FSM state encodings, transfer size codes and the store-strobe decoder.
package data_sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Returns {legal, size}; only naturally aligned byte/half/word strobes are legal.
  function automatic logic [2:0] strobe_decode(input logic [3:0] wen);
    logic [2:0] res;
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: res = {1'b1, SIZE_BYTE};
      4'b0011, 4'b1100:                   res = {1'b1, SIZE_HALF};
      4'b1111:                            res = {1'b1, SIZE_WORD};
      default:                            res = {1'b0, SIZE_BYTE};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/data_sram_ctrl_addr_map.sv
// Virtual-to-physical address translation for kseg0/kseg1 accesses.
// Only instantiated when ADDR_MAP_EN is defined.
module data_sram_ctrl_addr_map (
  input  logic [31:0] vaddr,
  output logic [31:0] paddr
);

  // kseg0/kseg1 (top bits 2'b10) fold onto the low 512 MB of physical space.
  assign paddr = (vaddr[31:30] == 2'b10) ? {3'b000, vaddr[28:0]} : vaddr;

endmodule

// File: rtl/data_sram_ctrl.sv
// M-stage load/store front end for an sram-like data bus.
// One transaction at a time: issue, wait for addr_ok, wait for data_ok,
// then hold the result until the pipeline is free to move on.
// Optional feature macro: ADDR_MAP_EN (kseg0/kseg1 address folding).
//
// state | meaning
// IDLE  | no transaction; a valid, unflushed mem_en issues a request
// ADDR  | request presented, waiting for data_addr_ok (fields frozen)
// DATA  | address accepted, waiting for data_data_ok
// HOLD  | result captured in mem_rdata, waiting for the pipeline to advance
import data_sram_ctrl_pkg::*;

module data_sram_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [1:0]  mem_load_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        flush,
  input  logic        longest_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall
);

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        lat_wr_q, lat_wr_d;
  logic [1:0]  lat_size_q, lat_size_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;

  logic [31:0] req_addr;
  logic [2:0]  strobe_dec;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_legal;
  logic        issue;
  logic        in_addr;

`ifdef ADDR_MAP_EN
  data_sram_ctrl_addr_map u_addr_map (
    .vaddr (mem_addr),
    .paddr (req_addr)
  );
`else
  assign req_addr = mem_addr;
`endif

  // Request fields as seen from the M stage this cycle.
  always_comb begin
    strobe_dec = strobe_decode(mem_wen);
    req_wr     = |mem_wen;
    req_size   = req_wr ? strobe_dec[1:0] : mem_load_size;
    req_legal  = !req_wr || strobe_dec[2];
  end

  // Issue qualification and bus outputs; ADDR replays the frozen copy so the
  // bus sees stable fields even if the M-stage inputs move (e.g. a late flush).
  always_comb begin
    in_addr    = (state_q == ST_ADDR);
    issue      = resetn && (state_q == ST_IDLE) && mem_en && !flush && req_legal;
    data_req   = issue || (resetn && in_addr);
    data_wr    = in_addr ? lat_wr_q    : req_wr;
    data_size  = in_addr ? lat_size_q  : req_size;
    data_addr  = in_addr ? lat_addr_q  : req_addr;
    data_wdata = in_addr ? lat_wdata_q : mem_wdata;
    mem_stall  = resetn && (((state_q == ST_IDLE) && mem_en && !flush) ||
                            in_addr || (state_q == ST_DATA));
    mem_rdata  = rdata_q;
  end

  // Next-state, result capture and request-field freeze.
  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    lat_wr_d    = lat_wr_q;
    lat_size_d  = lat_size_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          state_d     = data_addr_ok ? ST_DATA : ST_ADDR;
          lat_wr_d    = req_wr;
          lat_size_d  = req_size;
          lat_addr_d  = req_addr;
          lat_wdata_d = mem_wdata;
        end
      end
      ST_ADDR: begin
        if (data_addr_ok) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (data_data_ok) begin
          rdata_d = data_rdata;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!longest_stall || flush) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      rdata_q     <= '0;
      lat_wr_q    <= 1'b0;
      lat_size_q  <= SIZE_BYTE;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      lat_wr_q    <= lat_wr_d;
      lat_size_q  <= lat_size_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
    end
  end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Randomized transaction-level bench for data_sram_ctrl.
// Expected behaviour comes from a per-transaction model: stall length equals
// addr latency + data latency + 2, bus fields follow the strobe/size and
// address-map rules, and the captured word is the one returned with data_ok.
module tb_data_sram_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [1:0]  mem_load_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        flush;
  logic        longest_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] mem_rdata;
  logic        mem_stall;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  data_sram_ctrl dut (
    .clk           (clk),
    .resetn        (resetn),
    .mem_en        (mem_en),
    .mem_wen       (mem_wen),
    .mem_load_size (mem_load_size),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .flush         (flush),
    .longest_stall (longest_stall),
    .data_req      (data_req),
    .data_wr       (data_wr),
    .data_size     (data_size),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_addr_ok  (data_addr_ok),
    .data_data_ok  (data_data_ok),
    .data_rdata    (data_rdata),
    .mem_rdata     (mem_rdata),
    .mem_stall     (mem_stall)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference rules for the bus fields.
  function automatic logic [1:0] model_size(input logic [3:0] wen, input logic [1:0] lsize);
    int ones;
    ones = $countones(wen);
    if (ones == 0) return lsize;
    if (ones == 1) return 2'd0;
    if (ones == 2) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] model_addr(input logic [31:0] a);
`ifdef ADDR_MAP_EN
    if (a[31:30] == 2'b10) return a & 32'h1FFF_FFFF;
`endif
    return a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction starting in IDLE just after a rising edge.
  // a_lat/d_lat: wait cycles before addr_ok/data_ok; hold: cycles of
  // longest_stall after data_ok; noisy: perturb M-stage inputs and flush
  // once the request is in flight.
  task automatic run_txn(input logic [3:0] wen, input logic [1:0] lsize,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int a_lat, input int d_lat,
                         input int hold, input bit noisy);
    logic [1:0]  e_size;
    logic [31:0] e_addr;
    e_size = model_size(wen, lsize);
    e_addr = model_addr(addr);
    mem_en = 1'b1; mem_wen = wen; mem_load_size = lsize;
    mem_addr = addr; mem_wdata = wdata; flush = 1'b0; longest_stall = 1'b0;
    for (int i = 0; i <= a_lat; i++) begin
      data_addr_ok = (i == a_lat);
      data_data_ok = 1'($urandom);
      data_rdata   = $urandom;
      if (noisy && i > 0) begin
        mem_addr = $urandom; mem_wdata = $urandom; flush = 1'($urandom);
      end
      @(negedge clk);
      chk_eq("addr_req",   32'(data_req), 32'd1);
      chk_eq("addr_wr",    32'(data_wr), 32'(wen != 4'b0000));
      chk_eq("addr_size",  32'(data_size), 32'(e_size));
      chk_eq("addr_addr",  data_addr, e_addr);
      chk_eq("addr_wdata", data_wdata, wdata);
      chk_eq("addr_stall", 32'(mem_stall), 32'd1);
      step();
    end
    for (int j = 0; j <= d_lat; j++) begin
      data_addr_ok = 1'b0;
      data_data_ok = (j == d_lat);
      data_rdata   = (j == d_lat) ? rdata : $urandom;
      flush        = noisy ? 1'($urandom) : 1'b0;
      @(negedge clk);
      chk_eq("data_req",   32'(data_req), 32'd0);
      chk_eq("data_stall", 32'(mem_stall), 32'd1);
      step();
    end
    data_data_ok = 1'b0;
    data_rdata   = $urandom;
    for (int h = 0; h <= hold; h++) begin
      if (h < hold) begin
        longest_stall = 1'b1; flush = 1'b0;
      end else if (noisy && $urandom_range(0, 1) == 1) begin
        longest_stall = 1'b1; flush = 1'b1;
      end else begin
        longest_stall = 1'b0; flush = 1'b0;
      end
      data_data_ok = 1'($urandom);
      @(negedge clk);
      chk_eq("hold_req",   32'(data_req), 32'd0);
      chk_eq("hold_stall", 32'(mem_stall), 32'd0);
      chk_eq("hold_rdata", mem_rdata, rdata);
      step();
    end
    data_data_ok = 1'b0; longest_stall = 1'b0; flush = 1'b0;
    last_rdata = rdata;
  endtask

  logic [3:0] strobes [7];

  initial begin
    logic [3:0] w;
    logic [31:0] a;
    strobes = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    resetn = 1'b0; mem_en = 1'b1; mem_wen = 4'b0000; mem_load_size = 2'd2;
    mem_addr = 32'h0000_0100; mem_wdata = '0; flush = 1'b0; longest_stall = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    last_rdata = '0;

    // Reset holds everything quiet even with a pending mem_en.
    @(negedge clk);
    chk_eq("rst_req",   32'(data_req), 32'd0);
    chk_eq("rst_stall", 32'(mem_stall), 32'd0);
    chk_eq("rst_rdata", mem_rdata, 32'd0);
    mem_en = 1'b0;
    step();
    resetn = 1'b1;
    step();

    // Store byte lane 2: addr_ok at cycle 0, data_ok at cycle 2.
    run_txn(4'b0100, 2'd0, 32'h0000_0002, 32'h5555_5555, 32'h1111_2222, 0, 1, 0, 1'b0);

    // Load word from kseg0.
    run_txn(4'b0000, 2'd2, 32'h8000_1000, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 1'b0);

    // Slow address handshake with perturbed M-stage inputs.
    run_txn(4'b0000, 2'd1, 32'hA000_2002, 32'h0, 32'hCAFE_0001, 3, 0, 0, 1'b1);

    // Result held for 4 cycles of external stall.
    run_txn(4'b0000, 2'd0, 32'h0000_0013, 32'h0, 32'h0BAD_F00D, 0, 0, 4, 1'b0);

    // Flush in IDLE cancels the request.
    mem_en = 1'b1; mem_wen = 4'b1111; mem_addr = 32'h0000_0040; flush = 1'b1;
    @(negedge clk);
    chk_eq("flush_idle_req",   32'(data_req), 32'd0);
    chk_eq("flush_idle_stall", 32'(mem_stall), 32'd0);
    step();

    // Illegal strobe pattern never reaches the bus.
    mem_wen = 4'b0101; flush = 1'b0;
    @(negedge clk);
    chk_eq("bad_strobe_req", 32'(data_req), 32'd0);
    step();
    mem_en = 1'b0; mem_wen = 4'b0000;
    step();

    // Randomized back-to-back traffic.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1) w = strobes[$urandom_range(0, 6)];
      else w = 4'b0000;
      a = $urandom;
      if ($urandom_range(0, 2) == 0) a[31:30] = 2'b10;
      run_txn(w, 2'($urandom_range(0, 2)), a, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        mem_en = 1'($urandom); flush = 1'b1;
        @(negedge clk);
        chk_eq("idle_req",   32'(data_req), 32'd0);
        chk_eq("idle_stall", 32'(mem_stall), 32'd0);
        chk_eq("idle_rdata", mem_rdata, last_rdata);
        step();
        flush = 1'b0;
      end
    end

    // Reset in DATA abandons the transaction; a late data_ok is ignored.
    mem_en = 1'b1; mem_wen = 4'b0000; mem_load_size = 2'd2; mem_addr = 32'h0000_0200;
    flush = 1'b0; data_addr_ok = 1'b1;
    @(negedge clk);
    chk_eq("rst2_req", 32'(data_req), 32'd1);
    step();
    mem_en = 1'b0; data_addr_ok = 1'b0;
    @(negedge clk);
    chk_eq("rst2_in_data", 32'(mem_stall), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk_eq("rst2_rdata", mem_rdata, 32'd0);
    chk_eq("rst2_req0",  32'(data_req), 32'd0);
    chk_eq("rst2_stall", 32'(mem_stall), 32'd0);
    step();
    resetn = 1'b1;
    data_data_ok = 1'b1; data_rdata = 32'h7777_8888;
    @(negedge clk);
    chk_eq("late_ok_stall", 32'(mem_stall), 32'd0);
    step();
    data_data_ok = 1'b0;
    @(negedge clk);
    chk_eq("late_ok_rdata", mem_rdata, 32'd0);
    step();

    // Controller still works after the abandoned transaction.
    run_txn(4'b1100, 2'd0, 32'h8000_0302, 32'hABCD_ABCD, 32'h1234_5678, 1, 2, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
